// File: rtl/sd_tag_word_scanner_if.sv
// ---------------------------------------------------------------------------
// sd_tag_word_scanner_if
// Block-read bus between the tag/word scanner and the SD card controller.
//   rd_req   : one-cycle block read request (scanner -> controller)
//   rd_addr  : 32-bit block address, valid while rd_req is high
//   sd_dout  : byte from the controller
//   sd_valid : sd_dout carries a byte this cycle
// master = scanner side, slave = SD controller side.
// ---------------------------------------------------------------------------
interface sd_tag_word_scanner_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  sd_dout;
  logic        sd_valid;

  modport master (output rd_req, output rd_addr, input sd_dout, input sd_valid);
  modport slave  (input rd_req, input rd_addr, output sd_dout, output sd_valid);
endinterface

// File: rtl/sd_tag_word_scanner.sv
// ---------------------------------------------------------------------------
// sd_tag_word_scanner
// Requests consecutive 512-byte blocks from the SD controller starting at
// START_BLK and scans the byte stream without buffering: after START_TAG it
// counts case-insensitive, delimiter-bounded occurrences of WORD until
// END_TAG is seen or MAX_BLKS blocks have been received.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   start          : begin a scan (idle/done only, needs init_finished)
//   init_finished  : SD controller ready
//   sd             : block-read bus (rd_req/rd_addr out, sd_dout/sd_valid in)
//   busy, done     : scan in progress / scan finished, results held
//   found_end      : END_TAG seen during the scan
//   match_cnt      : saturating keyword count, overflow set on saturation
//   blk_cnt        : blocks fully received in this scan
// ---------------------------------------------------------------------------
module sd_tag_word_scanner #(
  parameter logic [31:0]            START_BLK = 32'h2000,
  parameter int                     MAX_BLKS  = 1024,
  parameter int                     TAG_LEN   = 8,
  parameter logic [TAG_LEN*8-1:0]   START_TAG = "DLAB_TAG",
  parameter logic [TAG_LEN*8-1:0]   END_TAG   = "DLAB_END",
  parameter int                     WORD_LEN  = 3,
  parameter logic [WORD_LEN*8-1:0]  WORD      = "the",
  parameter int                     CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 init_finished,
  sd_tag_word_scanner_if.master sd,
  output logic                 busy,
  output logic                 done,
  output logic                 found_end,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 overflow,
  output logic [31:0]          blk_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RECV = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] P_SEEK  = 2'd0;
  localparam logic [1:0] P_COUNT = 2'd1;
  localparam logic [1:0] P_AFTER = 2'd2;

  localparam int          TW   = TAG_LEN * 8;
  localparam logic [3:0]  WLEN = 4'(WORD_LEN);
  localparam logic [3:0]  WSAT = 4'(WORD_LEN + 1);
  localparam logic [31:0] MAXB = 32'(MAX_BLKS);

  logic [2:0]       state_reg;
  logic [1:0]       phase_reg;
  logic [9:0]       byte_cnt_reg;
  logic [TW-1:0]    window_reg;
  logic [3:0]       tok_len_reg;
  logic             tok_match_reg;
  logic [31:0]      rd_addr_reg;
  logic [CNT_W-1:0] match_cnt_reg;
  logic             overflow_reg;
  logic             found_end_reg;
  logic [31:0]      blk_cnt_reg;

  // Keyword bytes, index 0 = first character; unused slots are zero.
  logic [7:0] word_byte [0:7];
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    if (gi < WORD_LEN) begin : g_used
      assign word_byte[gi] = WORD[(WORD_LEN-1-gi)*8 +: 8];
    end else begin : g_unused
      assign word_byte[gi] = 8'h00;
    end
  end

  logic          accept;
  logic [TW-1:0] window_next;
  logic          start_hit, end_hit;
  logic          is_upper, is_lower, is_digit, is_tok;
  logic [7:0]    folded;
  logic          word_hit, end_now, last_byte;
  logic [31:0]   blk_inc;

  assign accept      = (state_reg == S_RECV) && sd.sd_valid;
  // Window holds the last TAG_LEN bytes including the one being accepted,
  // so a tag is recognised on the cycle its final byte arrives.
  assign window_next = TW'({window_reg, sd.sd_dout});
  assign start_hit   = (window_next == START_TAG);
  assign end_hit     = (window_next == END_TAG);
  assign is_upper    = (sd.sd_dout >= 8'h41) && (sd.sd_dout <= 8'h5A);
  assign is_lower    = (sd.sd_dout >= 8'h61) && (sd.sd_dout <= 8'h7A);
  assign is_digit    = (sd.sd_dout >= 8'h30) && (sd.sd_dout <= 8'h39);
  assign is_tok      = is_upper || is_lower || is_digit;
  assign folded      = is_upper ? (sd.sd_dout | 8'h20) : sd.sd_dout;
  assign word_hit    = (tok_len_reg == WLEN) && tok_match_reg;
  // found_end including an END_TAG completed by the byte being accepted now
  assign end_now     = found_end_reg || ((phase_reg == P_COUNT) && end_hit);
  assign last_byte   = (byte_cnt_reg == 10'd511);
  assign blk_inc     = blk_cnt_reg + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      phase_reg     <= P_SEEK;
      byte_cnt_reg  <= '0;
      window_reg    <= '0;
      tok_len_reg   <= '0;
      tok_match_reg <= 1'b1;
      rd_addr_reg   <= START_BLK;
      match_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
      found_end_reg <= 1'b0;
      blk_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start && init_finished) begin
            state_reg     <= S_REQ;
            phase_reg     <= P_SEEK;
            byte_cnt_reg  <= '0;
            window_reg    <= '0;
            tok_len_reg   <= '0;
            tok_match_reg <= 1'b1;
            rd_addr_reg   <= START_BLK;
            match_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            found_end_reg <= 1'b0;
            blk_cnt_reg   <= '0;
          end
        end
        S_REQ: state_reg <= S_RECV;
        S_RECV: begin
          if (accept) begin
            window_reg   <= window_next;
            byte_cnt_reg <= byte_cnt_reg + 10'd1;
            case (phase_reg)
              P_SEEK: begin
                // The tag's last byte ends any token, so counting starts clean.
                if (start_hit) begin
                  phase_reg     <= P_COUNT;
                  tok_len_reg   <= '0;
                  tok_match_reg <= 1'b1;
                end
              end
              P_COUNT: begin
                if (end_hit) begin
                  // Any partially built token is dropped with the tag.
                  found_end_reg <= 1'b1;
                  phase_reg     <= P_AFTER;
                  tok_len_reg   <= '0;
                  tok_match_reg <= 1'b1;
                end else if (is_tok) begin
                  if (tok_len_reg < WLEN)
                    tok_match_reg <= tok_match_reg && (folded == word_byte[tok_len_reg[2:0]]);
                  if (tok_len_reg != WSAT)
                    tok_len_reg <= tok_len_reg + 4'd1;
                end else begin
                  if (word_hit) begin
                    if (&match_cnt_reg) overflow_reg <= 1'b1;
                    else                match_cnt_reg <= match_cnt_reg + 1'b1;
                  end
                  tok_len_reg   <= '0;
                  tok_match_reg <= 1'b1;
                end
              end
              default: ;
            endcase
            if (last_byte) begin
              blk_cnt_reg <= blk_inc;
              state_reg   <= (end_now || (blk_inc >= MAXB)) ? S_DONE : S_NEXT;
            end
          end
        end
        S_NEXT: begin
          rd_addr_reg  <= rd_addr_reg + 32'd1;
          byte_cnt_reg <= '0;
          state_reg    <= S_REQ;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign sd.rd_req  = (state_reg == S_REQ);
  assign sd.rd_addr = rd_addr_reg;
  assign busy       = (state_reg == S_REQ) || (state_reg == S_RECV) || (state_reg == S_NEXT);
  assign done       = (state_reg == S_DONE);
  assign found_end  = found_end_reg;
  assign match_cnt  = match_cnt_reg;
  assign overflow   = overflow_reg;
  assign blk_cnt    = blk_cnt_reg;

endmodule

// File: tb/tb_sd_tag_word_scanner.sv
// ---------------------------------------------------------------------------
// tb_sd_tag_word_scanner
// Bench for sd_tag_word_scanner (MAX_BLKS=3, CNT_W=2). An SD controller
// stand-in serves blocks from a small image with random gaps; a behavioural
// model built on byte queues predicts every output each cycle. Directed
// scans carry hand-computed final results.
// ---------------------------------------------------------------------------
module tb_sd_tag_word_scanner;
  localparam int          MAX_BLKS  = 3;
  localparam int          CNT_W     = 2;
  localparam int          TAG_LEN   = 8;
  localparam logic [31:0] START_BLK = 32'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, start, init_finished;
  logic             busy, done, found_end, overflow;
  logic [CNT_W-1:0] match_cnt;
  logic [31:0]      blk_cnt;

  sd_tag_word_scanner_if sd_if();

  sd_tag_word_scanner #(.MAX_BLKS(MAX_BLKS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .init_finished(init_finished),
    .sd(sd_if), .busy(busy), .done(done), .found_end(found_end),
    .match_cnt(match_cnt), .overflow(overflow), .blk_cnt(blk_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- block image served by the controller stand-in --------
  logic [7:0] img [0:3][0:511];

  task automatic clear_img();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 512; i++) img[b][i] = 8'h00;
  endtask

  task automatic put_str(input int gpos, input string s);
    for (int i = 0; i < s.len(); i++)
      if (gpos + i < 2048) img[(gpos+i)/512][(gpos+i)%512] = 8'(s[i]);
  endtask

  function automatic logic [7:0] img_byte(input logic [31:0] a, input int i);
    logic [31:0] off;
    off = a - START_BLK;
    if (off < 32'd4) return img[off[1:0]][i];
    return 8'h00;
  endfunction

  // ---------------- behavioural model --------------------------------------
  typedef enum {M_IDLE, M_REQ, M_RECV, M_NEXT, M_DONE} mstate_t;
  mstate_t          m_state;
  int               m_phase;   // 0 before start tag, 1 counting, 2 after end tag
  int               m_nbytes, m_blk;
  logic [31:0]      m_addr;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf, m_found;
  bit               model_ready = 0;
  byte unsigned     hist[$];
  byte unsigned     tok[$];
  string            start_s = "DLAB_TAG";
  string            end_s   = "DLAB_END";
  string            word_s  = "the";

  function automatic bit hist_is(input string t);
    if (hist.size() != t.len()) return 0;
    for (int i = 0; i < t.len(); i++) if (hist[i] != 8'(t[i])) return 0;
    return 1;
  endfunction

  function automatic bit tok_is_word();
    if (tok.size() != word_s.len()) return 0;
    for (int i = 0; i < word_s.len(); i++) if (tok[i] != 8'(word_s[i])) return 0;
    return 1;
  endfunction

  function automatic void model_clear();
    m_phase = 0; m_nbytes = 0; m_blk = 0; m_cnt = '0; m_ovf = 0; m_found = 0;
    hist.delete(); tok.delete();
  endfunction

  function automatic void model_byte(input byte unsigned b);
    bit alpha, digit;
    alpha = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    digit = (b >= 8'h30 && b <= 8'h39);
    hist.push_back(b);
    if (hist.size() > TAG_LEN) void'(hist.pop_front());
    if (m_phase == 0) begin
      if (hist_is(start_s)) begin m_phase = 1; tok.delete(); end
    end else if (m_phase == 1) begin
      if (hist_is(end_s)) begin
        m_found = 1; m_phase = 2; tok.delete();
      end else if (alpha || digit) begin
        tok.push_back((b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b);
      end else begin
        if (tok_is_word()) begin
          if (m_cnt == {CNT_W{1'b1}}) m_ovf = 1;
          else m_cnt = m_cnt + 1'b1;
        end
        tok.delete();
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_state = M_IDLE; m_addr = START_BLK; model_clear();
      end else begin
        case (m_state)
          M_IDLE, M_DONE:
            if (start && init_finished) begin
              model_clear(); m_addr = START_BLK; m_state = M_REQ;
            end
          M_REQ: begin m_state = M_RECV; m_nbytes = 0; end
          M_RECV:
            if (sd_if.sd_valid) begin
              model_byte(sd_if.sd_dout);
              m_nbytes++;
              if (m_nbytes == 512) begin
                m_blk++;
                m_state = (m_found || m_blk >= MAX_BLKS) ? M_DONE : M_NEXT;
              end
            end
          M_NEXT: begin m_addr = m_addr + 1; m_state = M_REQ; end
          default: m_state = M_IDLE;
        endcase
      end
      model_ready = 1;
    end
  end

  // one compare per cycle of every output against the model
  initial begin
    wait (model_ready);
    forever begin
      @(negedge clk);
      check("cycle",
            {sd_if.rd_req, sd_if.rd_addr, busy, done, found_end, match_cnt, overflow, blk_cnt},
            {m_state == M_REQ, m_addr,
             (m_state == M_REQ) || (m_state == M_RECV) || (m_state == M_NEXT),
             m_state == M_DONE, m_found, m_cnt, m_ovf, 32'(m_blk)});
    end
  end

  // ---------------- SD controller stand-in ---------------------------------
  logic [31:0] reqs[$];
  int          gaps[$];
  int          resp_idx, cyc = 0, last_cyc, delay;
  bit          pending = 0, have_last = 0;
  logic [31:0] cur_addr;

  initial begin
    sd_if.sd_valid = 1'b0;
    sd_if.sd_dout  = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!reset_n || (pending && !busy)) begin
        pending = 0; have_last = 0; sd_if.sd_valid = 1'b0;
      end else if (sd_if.rd_req) begin
        reqs.push_back(sd_if.rd_addr);
        if (have_last) gaps.push_back(cyc - last_cyc);
        have_last = 0; pending = 1; cur_addr = sd_if.rd_addr; resp_idx = 0;
        delay = $urandom_range(0, 3);
        sd_if.sd_valid = 1'b0;
      end else if (pending) begin
        if (delay > 0) begin
          delay--; sd_if.sd_valid = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          sd_if.sd_valid = 1'b0;
        end else begin
          sd_if.sd_valid = 1'b1;
          sd_if.sd_dout  = img_byte(cur_addr, resp_idx);
          resp_idx++;
          if (resp_idx == 512) begin pending = 0; have_last = 1; last_cyc = cyc; end
        end
      end else begin
        // stray bytes while no block is outstanding must be ignored
        sd_if.sd_valid = ($urandom_range(0, 2) == 0);
        sd_if.sd_dout  = 8'($urandom);
        if (!busy) have_last = 0;
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_scan(input string name, input bit poke);
    bit seen;
    seen = 0;
    reqs.delete(); gaps.delete();
    pulse_start();
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 300) start = 1'b1;
      if (i == 301) start = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: done not seen, required within 6000 cycles", name);
    end
    $display("scan %s: match_cnt=%0d overflow=%0d found_end=%0d blk_cnt=%0d reqs=%0d",
             name, match_cnt, overflow, found_end, blk_cnt, reqs.size());
  endtask

  string alpha = "theTHE x1,_\nhtethe";

  initial begin
    reset_n = 1'b0; start = 1'b0; init_finished = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_rd_addr", sd_if.rd_addr, 32'h2000);
    check("reset_flags", {sd_if.rd_req, busy, done, found_end, overflow}, 5'b0);
    check("reset_counts", {match_cnt, blk_cnt}, '0);

    // start is ignored while the controller is not ready
    pulse_start();
    repeat (3) @(negedge clk);
    check("start_without_init", {busy, done}, 2'b00);
    init_finished = 1'b1;

    // 1: single block
    clear_img();
    put_str(0, "DLAB_TAG the The\nTHE thee DLAB_END");
    run_scan("single_block", 0);
    check("s1_cnt", {overflow, match_cnt}, {1'b0, 2'd3});
    check("s1_found_blk_done", {found_end, blk_cnt, done}, {1'b1, 32'd1, 1'b1});
    check("s1_reqs", {32'(reqs.size()), (reqs.size() > 0) ? reqs[0] : 32'h0}, {32'd1, 32'h2000});

    // 2: start tag ends at byte 510, body and end tag in the next block
    clear_img();
    put_str(503, "DLAB_TAG");
    put_str(512, "the DLAB_END");
    run_scan("straddle", 0);
    check("s2_cnt_blk", {match_cnt, blk_cnt, found_end}, {2'd1, 32'd2, 1'b1});
    check("s2_addr1", (reqs.size() > 1) ? reqs[1] : 32'h0, 32'h2001);
    check("s2_turnaround", (gaps.size() > 0) ? 32'(gaps[0]) : 32'hFFFF_FFFF, 32'd2);

    // 3: no end tag, stops after MAX_BLKS blocks
    clear_img();
    put_str(0, "DLAB_TAG the ");
    put_str(512, "the ");
    put_str(1024, "the ");
    run_scan("no_end", 0);
    check("s3_reqs", {32'(reqs.size()), (reqs.size() > 2) ? reqs[2] : 32'h0}, {32'd3, 32'h2002});
    check("s3_result", {done, found_end, blk_cnt, match_cnt}, {1'b1, 1'b0, 32'd3, 2'd3});

    // 4: five matches saturate a 2-bit counter; a start mid-scan is ignored
    clear_img();
    put_str(0, "DLAB_TAG the the the the the DLAB_END");
    run_scan("saturate", 1);
    check("s4_sat", {match_cnt, overflow}, {2'd3, 1'b1});

    // 5: delimiter handling
    clear_img();
    put_str(0, "DLAB_TAG xthe the_the,the DLAB_END");
    run_scan("delims", 0);
    check("s5_cnt", {match_cnt, overflow}, {2'd3, 1'b0});

    // 6: reset mid-block, then a fresh scan
    clear_img();
    put_str(0, "DLAB_TAG the The\nTHE thee DLAB_END");
    reqs.delete();
    pulse_start();
    for (int i = 0; i < 2000 && !(pending && resp_idx >= 100); i++) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("s6_reset_flags", {sd_if.rd_req, busy, done, found_end, overflow}, 5'b0);
    check("s6_reset_vals", {sd_if.rd_addr, match_cnt, blk_cnt}, {32'h2000, 2'd0, 32'd0});
    repeat (20) @(negedge clk);
    run_scan("after_reset", 0);
    check("s6_rescan", {(reqs.size() > 0) ? reqs[0] : 32'h0, match_cnt, blk_cnt},
          {32'h2000, 2'd3, 32'd1});

    // random content, tags at random (possibly straddling) positions
    for (int r = 0; r < 6; r++) begin
      int sp;
      clear_img();
      for (int b = 0; b < 3; b++)
        for (int i = 0; i < 512; i++)
          img[b][i] = 8'(alpha[$urandom_range(0, alpha.len() - 1)]);
      sp = $urandom_range(0, 900);
      put_str(sp, "DLAB_TAG");
      if ($urandom_range(0, 2) == 0) put_str(sp + 8 + $urandom_range(0, 40), "DLAB_TAG");
      if ($urandom_range(0, 3) != 0) put_str(sp + 8 + $urandom_range(0, 500), "DLAB_END");
      run_scan($sformatf("random%0d", r), r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
